muldiv_iter: RTL and testbench

Parametrised HI/LO multiply-divide unit for the EX stage of the pipelined MIPS core. It replaces the fixed-latency behavioural unit with a WIDTH-generic block. Multiply uses a pipelined product with configurable latency. Divide is a true iterative restoring divider. The block adds multiply-accumulate (madd/maddu/msub/msubu) and precise exception cancellation. The hazard unit stalls on `start_o | busy_o` for HI/LO readers and for new mul/div ops.

---
 rtl/muldiv_iter.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: HI/LO multiply-divide unit for the EX stage.
//
// Multiply-class ops (mult/multu/madd/maddu/msub/msubu) form the full
// 2*WIDTH product at issue and hold it for MUL_CYCLES busy cycles. On the
// last cycle, {hi,lo} is written with the product, {hi,lo}+product or
// {hi,lo}-product. Divides run one restoring step per cycle for WIDTH
// cycles. A final FIX cycle then applies the signs. mthi/mtlo write in a
// single cycle and never raise busy.
//
// Handshake: start_o is high whenever op_i names a multiply or divide. It
// is purely combinational and is not gated by cancel_i or busy_o. An op is
// accepted only in IDLE with cancel_i low. Any op presented while busy_o=1
// is dropped, so the hazard unit must stall on start_o | busy_o. cancel_i
// aborts an op only in its first busy cycle. In later cycles it is ignored.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   a_i, b_i          rs / rt operands (a_i also feeds mthi/mtlo)
//   op_i              operation code (see op decode below)
//   cancel_i          exception/flush from EX/MEM
//   start_o           op_i is a multiply/divide (combinational)
//   busy_o            operation in flight
//   hi_o, lo_o        architectural HI/LO registers
module muldiv_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             cancel_i,
  output logic             start_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int W2      = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

  state_e           state_q, state_d;
  acc_e             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Multiplier operands are sign- or zero-extended to 2*WIDTH. The
  // truncated 2*WIDTH product is then correct for both signednesses.
  logic          mul_signed;
  logic [W2-1:0] mul_a, mul_b, mul_p;
  logic          div_signed, a_neg, b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [W2-1:0]    hilo, acc_res;

  assign start_o = (op_i >= 4'd1) && (op_i <= 4'd8);
  assign busy_o  = (state_q != S_IDLE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    mul_signed = (op_i == 4'd1) || (op_i == 4'd5) || (op_i == 4'd7);
    mul_a = mul_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    mul_b = mul_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    mul_p = mul_a * mul_b;

    div_signed = (op_i == 4'd3);
    a_neg      = div_signed & a_i[WIDTH-1];
    b_neg      = div_signed & b_i[WIDTH-1];

    // One restoring step. The remainder is always below the divisor, so
    // WIDTH bits of remainder plus the incoming dividend bit is enough.
    // A zero divisor always passes the trial subtract. That yields an
    // all-ones quotient and leaves the dividend as the remainder.
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    diff    = shifted[WIDTH-1:0] - dvs_q;

    hilo = {hi_q, lo_q};
    case (acc_q)
      ACC_ADD: acc_res = hilo + prod_q;
      ACC_SUB: acc_res = hilo - prod_q;
      default: acc_res = prod_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!cancel_i) begin
          case (op_i)
            4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: begin
              prod_d  = mul_p;
              cnt_d   = CW'(MUL_CYCLES);
              first_d = 1'b1;
              if (op_i == 4'd5 || op_i == 4'd6)      acc_d = ACC_ADD;
              else if (op_i == 4'd7 || op_i == 4'd8) acc_d = ACC_SUB;
              else                                   acc_d = ACC_NONE;
              state_d = S_MUL;
            end
            4'd3, 4'd4: begin
              quo_d   = a_neg ? -a_i : a_i;
              dvs_d   = b_neg ? -b_i : b_i;
              rem_d   = '0;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = CW'(WIDTH);
              first_d = 1'b1;
              state_d = S_DIV;
            end
            4'd9:    hi_d = a_i;
            4'd10:   lo_d = a_i;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        first_d = 1'b0;
        if (first_q && cancel_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = acc_res;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        first_d = 1'b0;
        if (first_q && cancel_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = ge ? diff : shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          if (cnt_q == CW'(1)) state_d = S_FIX;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        // The remainder follows the dividend's sign. MIN/-1 falls out
        // naturally: |MIN| is MIN, and negating MIN gives MIN again.
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_NONE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: a 32-bit/5-cycle instance and a
// 16-bit/1-cycle instance share the clock and reset.
module tb_muldiv_iter;

  logic        clk;
  logic        reset;
  logic [31:0] a_i, b_i;
  logic [3:0]  op_i;
  logic        cancel_i;
  logic        start_o, busy_o;
  logic [31:0] hi_o, lo_o;

  logic [15:0] a16, b16;
  logic [3:0]  op16;
  logic        cancel16;
  logic        start16, busy16;
  logic [15:0] hi16, lo16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  muldiv_iter #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .op_i(op_i),
    .cancel_i(cancel_i), .start_o(start_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  muldiv_iter #(.WIDTH(16), .MUL_CYCLES(1)) dut16 (
    .clk(clk), .reset(reset), .a_i(a16), .b_i(b16), .op_i(op16),
    .cancel_i(cancel16), .start_o(start16), .busy_o(busy16),
    .hi_o(hi16), .lo_o(lo16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit, optionally raising cancel_i in busy
  // cycle cancel_at (1 = first busy cycle), and count busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, output int cycles);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; cancel_i = 1'b0;
    @(negedge clk);
    op_i = 4'd0; a_i = '0; b_i = '0;
    cycles = 0;
    while (busy_o && cycles < 100) begin
      cycles++;
      cancel_i = (cycles == cancel_at);
      @(negedge clk);
    end
    cancel_i = 1'b0;
  endtask

  // Run an op and score the busy length and resulting {hi,lo}.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int cancel_at, input int exp_busy,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    logic [63:0] exp;
    exp_q.push_back({exp_hi, exp_lo});
    run_op(op, a, b, cancel_at, cyc);
    check({tag, "_busy"}, 64'(cyc), 64'(exp_busy));
    exp = exp_q.pop_front();
    check({tag, "_hilo"}, {hi_o, lo_o}, exp);
  endtask

  // mthi/mtlo (op 9/10) with an optional cancel.
  task automatic move(input logic [3:0] op, input logic [31:0] val, input logic cancel);
    @(negedge clk);
    op_i = op; a_i = val; cancel_i = cancel;
    @(negedge clk);
    op_i = 4'd0; a_i = '0; cancel_i = 1'b0;
  endtask

  task automatic run16(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int exp_busy,
                       input logic [15:0] exp_hi, input logic [15:0] exp_lo);
    int cyc;
    @(negedge clk);
    op16 = op; a16 = a; b16 = b;
    @(negedge clk);
    op16 = 4'd0; a16 = '0; b16 = '0;
    cyc = 0;
    while (busy16 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 64'(cyc), 64'(exp_busy));
    check({tag, "_hilo"}, {32'd0, hi16, lo16}, {32'd0, exp_hi, exp_lo});
  endtask

  initial begin
    reset = 1'b1;
    op_i = '0; a_i = '0; b_i = '0; cancel_i = 1'b0;
    op16 = '0; a16 = '0; b16 = '0; cancel16 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_start", 64'(start_o), 64'd0);

    // start_o is combinational and not gated by cancel; cancel makes IDLE
    // ignore the op, so these probes must not disturb HI/LO.
    cancel_i = 1'b1;
    op_i = 4'd3; #1 check("start_div", 64'(start_o), 64'd1);
    op_i = 4'd8; #1 check("start_msubu", 64'(start_o), 64'd1);
    op_i = 4'd9; #1 check("start_mthi", 64'(start_o), 64'd0);
    op_i = 4'd12; #1 check("start_rsvd", 64'(start_o), 64'd0);
    @(negedge clk);
    op_i = 4'd0; cancel_i = 1'b0;
    @(negedge clk);
    check("probe_busy", 64'(busy_o), 64'd0);
    check("probe_hilo", {hi_o, lo_o}, 64'd0);

    // multiply
    do_op("mult",  4'd1, 32'hFFFFFFFD, 32'd7, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("multu", 4'd2, 32'hFFFFFFFD, 32'd7, 0, 5, 32'h00000006, 32'hFFFFFFEB);

    // divide
    do_op("divu",    4'd4, 32'd100, 32'd7, 0, 33, 32'd2, 32'd14);
    do_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_nb",  4'd3, 32'd7, 32'hFFFFFFFE, 0, 33, 32'd1, 32'hFFFFFFFD);
    do_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 0, 33, 32'd0, 32'h80000000);
    do_op("divu_z",  4'd4, 32'h1234, 32'd0, 0, 33, 32'h1234, 32'hFFFFFFFF);

    // accumulate
    move(4'd9, 32'd0, 1'b0);
    move(4'd10, 32'd10, 1'b0);
    check("mt_hilo", {hi_o, lo_o}, {32'd0, 32'd10});
    do_op("madd",  4'd5, 32'd3, 32'd4, 0, 5, 32'd0, 32'd22);
    do_op("msub",  4'd7, 32'd5, 32'd5, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("maddu", 4'd6, 32'hFFFFFFFF, 32'd2, 0, 5, 32'd1, 32'hFFFFFFFB);
    do_op("msubu", 4'd8, 32'd1, 32'd1, 0, 5, 32'd1, 32'hFFFFFFFA);

    // cancellation
    move(4'd9, 32'hA, 1'b0);
    move(4'd10, 32'hB, 1'b0);
    do_op("div_c1",  4'd3, 32'd100, 32'd7, 1, 1, 32'hA, 32'hB);
    do_op("mult_c1", 4'd1, 32'd6, 32'd7, 1, 1, 32'hA, 32'hB);
    do_op("div_c3",  4'd3, 32'd100, 32'd7, 3, 33, 32'd2, 32'd14);
    move(4'd10, 32'h77, 1'b1);
    move(4'd9, 32'h55, 1'b1);
    check("mt_cancel", {hi_o, lo_o}, {32'd2, 32'd14});

    // reset in cycle 10 of a divide
    @(negedge clk);
    op_i = 4'd4; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    op_i = 4'd0; a_i = '0; b_i = '0;
    repeat (9) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy_o), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    do_op("mult_after_rst", 4'd1, 32'd6, 32'd7, 0, 5, 32'd0, 32'd42);

    // WIDTH=16, MUL_CYCLES=1 instance
    run16("w16_mult", 4'd1, 16'h8000, 16'h8000, 1, 16'h4000, 16'h0000);
    run16("w16_divu", 4'd4, 16'hFFFF, 16'd3, 17, 16'h0000, 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
